// File: rtl/led_wbm_pkg.sv
// Shared definitions for the LED sweep Wishbone master: state codes, bus
// constants and a small state-classification helper.
package led_wbm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_WR_ACK = 3'd2,
        ST_GAP    = 3'd3,
        ST_RD     = 3'd4,
        ST_RD_ACK = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    // Plain-vector aliases so the state register stays an ordinary logic vector.
    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_WR     = ST_WR;
    localparam logic [2:0] S_WR_ACK = ST_WR_ACK;
    localparam logic [2:0] S_GAP    = ST_GAP;
    localparam logic [2:0] S_RD     = ST_RD;
    localparam logic [2:0] S_RD_ACK = ST_RD_ACK;
    localparam logic [2:0] S_DONE   = ST_DONE;

    localparam logic [15:0] LED_ADDR       = 16'h0000;
    localparam logic [15:0] LED_START_DATA = 16'h0001;

    function automatic logic is_bus_state(input logic [2:0] s);
        return (s == S_WR) || (s == S_WR_ACK) || (s == S_RD) || (s == S_RD_ACK);
    endfunction

endpackage

// File: rtl/led_wbm_timeout.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags
// expiry on the LIMIT-th enabled cycle.
module wb_timeout #(
    parameter int LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign o_expire = i_enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable && !o_expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_wbm.sv
// Wishbone master that kicks off LED sweeps: writes the start word, then polls
// the slave's sweep index until it returns to idle, once per requested sweep.
module led_wbm
    import led_wbm_pkg::*;
#(
    parameter int POLL_GAP    = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [3:0]  i_count,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_cyc,
    output logic        o_stb,
    output logic        o_we,
    output logic [15:0] o_addr,
    output logic [15:0] o_data,
    input  logic        i_stall,
    input  logic        i_ack,
    input  logic [7:0]  i_data
);

    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = (POLL_GAP > 1) ? GW'(POLL_GAP - 1) : '0;

    logic [2:0]    state_q, state_d;
    logic [3:0]    remaining_q, remaining_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          err_q, err_d;

    logic       wr_xfer;
    logic       rd_xfer;
    logic [3:0] rem_dec;
    logic       tmo_clear;
    logic       tmo_expire;

    // Only the sweep index nibble of the read data carries meaning.
    logic unused_data;
    assign unused_data = &{1'b0, i_data[7:4]};

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        gap_d       = gap_q;
        err_d       = err_q;

        // An ack arriving together with strobe acceptance completes the transfer.
        wr_xfer = i_ack && (((state_q == S_WR) && !i_stall) || (state_q == S_WR_ACK));
        rd_xfer = i_ack && (((state_q == S_RD) && !i_stall) || (state_q == S_RD_ACK));
        rem_dec = (remaining_q != 4'd0) ? remaining_q - 4'd1 : 4'd0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    err_d = 1'b0;
                    if (i_count != 4'd0) begin
                        remaining_d = i_count;
                        state_d     = S_WR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WR:     if (!i_stall) state_d = S_WR_ACK;
            S_RD:     if (!i_stall) state_d = S_RD_ACK;
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_RD;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_WR_ACK, S_RD_ACK: ;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (wr_xfer) begin
            state_d = S_GAP;
            gap_d   = '0;
        end

        if (rd_xfer) begin
            if (i_data[3:0] != 4'd0) begin
                state_d = S_GAP;
                gap_d   = '0;
            end else begin
                remaining_d = rem_dec;
                state_d     = (rem_dec != 4'd0) ? S_WR : S_DONE;
            end
        end

        // A completed handshake in the same cycle wins over the watchdog.
        if (tmo_expire && !wr_xfer && !rd_xfer) begin
            state_d     = S_IDLE;
            err_d       = 1'b1;
            remaining_d = '0;
        end
    end

    assign tmo_clear = ((state_d == S_WR) && (state_q != S_WR)) ||
                       ((state_d == S_RD) && (state_q != S_RD));

    wb_timeout #(
        .LIMIT(ACK_TIMEOUT)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (tmo_clear),
        .i_enable (is_bus_state(state_q)),
        .o_expire (tmo_expire)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            gap_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            gap_q       <= gap_d;
            err_q       <= err_d;
        end
    end

    assign o_busy = (state_q != S_IDLE);
    assign o_done = (state_q == S_DONE);
    assign o_err  = err_q;
    assign o_cyc  = is_bus_state(state_q);
    assign o_stb  = (state_q == S_WR) || (state_q == S_RD);
    assign o_we   = (state_q == S_WR) || (state_q == S_WR_ACK);
    assign o_addr = LED_ADDR;
    assign o_data = o_we ? LED_START_DATA : 16'h0000;

endmodule
